// File: rtl/acsi_pkg.sv
// Shared types and constants for the ACSI sector transfer sequencer.
package acsi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DMA_FILL  = 3'd1,
    SD_REQ    = 3'd2,
    SD_WAIT   = 3'd3,
    DMA_DRAIN = 3'd4,
    ADVANCE   = 3'd5,
    WAIT_NEXT = 3'd6
  } seq_state_t;

  localparam int unsigned SECTOR_BYTES = 512;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  // Map the latched target index onto the per-target strobe bus.
  function automatic logic [1:0] tgt_onehot(input logic tgt);
    if (tgt) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/acsi_sector_seq_watchdog.sv
// Per-phase watchdog: counts while active, restarts on every phase change,
// flags expiry on the cycle whose increment would reach TIMEOUT_CYCLES.
module acsi_seq_watchdog #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clear,
  output logic expired
);

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  // Next count: restart on phase change or when idle, otherwise increment.
  always_comb begin
    if (clear || !active) begin
      cnt_d = 24'd0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  assign expired = active && (cnt_q == (TIMEOUT_CYCLES - 24'd1));

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acsi_sector_seq.sv
// Sector transfer sequencer between the ACSI command block, the SD controller
// and the DMA FIFO. Define ACSI_SEQ_TIMEOUT_EN to add a per-phase watchdog.
module acsi_sector_seq
  import acsi_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  data_rd_req,
  input  logic [1:0]  data_wr_req,
  input  logic [31:0] data_lba,
  input  logic [15:0] data_length,
  output logic        data_busy,
  output logic        data_done,
  output logic        data_next,
  output logic        dma_done,
  output logic        xfer_err,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [31:0] sd_lba,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic        dma_sec_done,
  input  logic        dma_scnt_zero
);

  seq_state_t  state_q, state_d;
  logic        target_q, target_d;
  logic        dir_q, dir_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic [15:0] remaining_q, remaining_d;

  logic [1:0]  sd_rd_q, sd_rd_d;
  logic [1:0]  sd_wr_q, sd_wr_d;
  logic        data_busy_q, data_busy_d;
  logic        data_done_q, data_done_d;
  logic        data_next_q, data_next_d;
  logic        dma_done_q, dma_done_d;
  logic        xfer_err_q, xfer_err_d;

  logic        new_cmd_s;
  logic        zero_len_s;
  logic        req_match_s;
  logic        expire_s;

`ifdef ACSI_SEQ_TIMEOUT_EN
  logic wd_active_s;
  logic wd_clear_s;

  assign wd_active_s = (state_q == DMA_FILL) || (state_q == SD_REQ) || (state_q == SD_WAIT) ||
                       (state_q == DMA_DRAIN) || (state_q == WAIT_NEXT);
  assign wd_clear_s  = (state_d != state_q);

  acsi_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (wd_active_s),
    .clear   (wd_clear_s),
    .expired (expire_s)
  );
`else
  logic unused_timeout_s;

  assign unused_timeout_s = ^TIMEOUT_CYCLES;
  assign expire_s         = 1'b0;
`endif

  // Continuation requests must come from the same target and direction.
  assign req_match_s = (dir_q == DIR_RD) ? data_rd_req[target_q] : data_wr_req[target_q];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= 1'b0;
      dir_q       <= DIR_RD;
      sd_lba_q    <= 32'd0;
      remaining_q <= 16'd0;
      sd_rd_q     <= 2'b00;
      sd_wr_q     <= 2'b00;
      data_busy_q <= 1'b0;
      data_done_q <= 1'b0;
      data_next_q <= 1'b0;
      dma_done_q  <= 1'b0;
      xfer_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      dir_q       <= dir_d;
      sd_lba_q    <= sd_lba_d;
      remaining_q <= remaining_d;
      sd_rd_q     <= sd_rd_d;
      sd_wr_q     <= sd_wr_d;
      data_busy_q <= data_busy_d;
      data_done_q <= data_done_d;
      data_next_q <= data_next_d;
      dma_done_q  <= dma_done_d;
      xfer_err_q  <= xfer_err_d;
    end
  end

  // Next-state logic and command context capture.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    dir_d       = dir_q;
    sd_lba_d    = sd_lba_q;
    remaining_d = remaining_q;
    new_cmd_s   = 1'b0;
    zero_len_s  = 1'b0;
    if (expire_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if ((|data_rd_req) || (|data_wr_req)) begin
            new_cmd_s   = 1'b1;
            sd_lba_d    = data_lba;
            remaining_d = data_length;
            if (|data_rd_req) begin
              dir_d    = DIR_RD;
              target_d = ~data_rd_req[0];
            end else begin
              dir_d    = DIR_WR;
              target_d = ~data_wr_req[0];
            end
            if (data_length == 16'd0) begin
              zero_len_s = 1'b1;
              state_d    = IDLE;
            end else if (dir_d == DIR_WR) begin
              state_d = DMA_FILL;
            end else begin
              state_d = SD_REQ;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DMA_FILL: begin
          if (dma_sec_done) begin
            state_d = SD_REQ;
          end else begin
            state_d = DMA_FILL;
          end
        end
        SD_REQ: begin
          if (sd_busy) begin
            state_d = SD_WAIT;
          end else begin
            state_d = SD_REQ;
          end
        end
        SD_WAIT: begin
          if (!sd_done) begin
            state_d = SD_WAIT;
          end else if (dir_q == DIR_RD) begin
            state_d = DMA_DRAIN;
          end else begin
            state_d = ADVANCE;
          end
        end
        DMA_DRAIN: begin
          if (dma_sec_done) begin
            state_d = ADVANCE;
          end else begin
            state_d = DMA_DRAIN;
          end
        end
        ADVANCE: begin
          remaining_d = remaining_q - 16'd1;
          if ((remaining_q == 16'd1) || dma_scnt_zero) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_NEXT;
          end
        end
        WAIT_NEXT: begin
          if (!req_match_s) begin
            state_d = WAIT_NEXT;
          end else begin
            sd_lba_d = data_lba;
            if (dir_q == DIR_WR) begin
              state_d = DMA_FILL;
            end else begin
              state_d = SD_REQ;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output logic: strobes follow the next state, pulses mark transitions.
  always_comb begin
    sd_rd_d     = 2'b00;
    sd_wr_d     = 2'b00;
    data_busy_d = 1'b0;
    data_done_d = 1'b0;
    data_next_d = 1'b0;
    dma_done_d  = 1'b0;
    xfer_err_d  = xfer_err_q;
    if ((state_d == SD_REQ) && (dir_d == DIR_RD)) begin
      sd_rd_d = tgt_onehot(target_d);
    end else if (state_d == SD_REQ) begin
      sd_wr_d = tgt_onehot(target_d);
    end else begin
      sd_rd_d = 2'b00;
      sd_wr_d = 2'b00;
    end
    data_busy_d = (state_q == SD_REQ) && (state_d == SD_WAIT);
    data_done_d = (state_q == SD_WAIT) && ((state_d == DMA_DRAIN) || (state_d == ADVANCE));
    data_next_d = (state_q == ADVANCE) && (state_d == WAIT_NEXT);
    dma_done_d  = zero_len_s || expire_s || ((state_q == ADVANCE) && (state_d == IDLE));
    if (expire_s) begin
      xfer_err_d = 1'b1;
    end else if (new_cmd_s) begin
      xfer_err_d = 1'b0;
    end else begin
      xfer_err_d = xfer_err_q;
    end
  end

  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign sd_lba    = sd_lba_q;
  assign data_busy = data_busy_q;
  assign data_done = data_done_q;
  assign data_next = data_next_q;
  assign dma_done  = dma_done_q;
  assign xfer_err  = xfer_err_q;

endmodule

// File: tb/tb_acsi_sector_seq.sv
// Directed bench for acsi_sector_seq: stimulus sets the expected protocol view
// for every cycle, one process compares it against the DUT at each negedge.
module tb_acsi_sector_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  data_rd_req = 2'b00;
  logic [1:0]  data_wr_req = 2'b00;
  logic [31:0] data_lba = 32'd0;
  logic [15:0] data_length = 16'd0;
  logic        data_busy, data_done, data_next, dma_done, xfer_err;
  logic [1:0]  sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_busy = 1'b0;
  logic        sd_done = 1'b0;
  logic        dma_sec_done = 1'b0;
  logic        dma_scnt_zero = 1'b0;

  logic [1:0]  e_rd = 2'b00;
  logic [1:0]  e_wr = 2'b00;
  logic [31:0] e_lba = 32'd0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic        e_next = 1'b0;
  logic        e_dd = 1'b0;
  logic        e_err = 1'b0;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int next_cnt = 0;

  acsi_sector_seq #(
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_rd_req   (data_rd_req),
    .data_wr_req   (data_wr_req),
    .data_lba      (data_lba),
    .data_length   (data_length),
    .data_busy     (data_busy),
    .data_done     (data_done),
    .data_next     (data_next),
    .dma_done      (dma_done),
    .xfer_err      (xfer_err),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_lba        (sd_lba),
    .sd_busy       (sd_busy),
    .sd_done       (sd_done),
    .dma_sec_done  (dma_sec_done),
    .dma_scnt_zero (dma_scnt_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; pulses are expected low unless the caller says otherwise.
  task automatic step();
    @(posedge clk);
    #1;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_next = 1'b0;
    e_dd   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sd_rd", 32'(sd_rd), 32'(e_rd));
      chk("sd_wr", 32'(sd_wr), 32'(e_wr));
      chk("sd_lba", sd_lba, e_lba);
      chk("data_busy", 32'(data_busy), 32'(e_busy));
      chk("data_done", 32'(data_done), 32'(e_done));
      chk("data_next", 32'(data_next), 32'(e_next));
      chk("dma_done", 32'(dma_done), 32'(e_dd));
      chk("xfer_err", 32'(xfer_err), 32'(e_err));
    end
    if (data_next === 1'b1) begin
      next_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Two-sector read, target 0, with a continuation request
    data_rd_req = 2'b01; data_lba = 32'h100; data_length = 16'd2;
    step(); e_rd = 2'b01; e_lba = 32'h100;
    step();
    sd_busy = 1'b1;
    step(); e_rd = 2'b00; e_busy = 1'b1;
    sd_busy = 1'b0; data_rd_req = 2'b00;
    step();
    sd_done = 1'b1;
    step(); e_done = 1'b1;
    sd_done = 1'b0;
    step();
    dma_sec_done = 1'b1;
    step();
    dma_sec_done = 1'b0;
    step(); e_next = 1'b1;
    step();
    data_wr_req = 2'b01;
    step();
    data_wr_req = 2'b00; data_rd_req = 2'b10;
    step();
    data_rd_req = 2'b01; data_lba = 32'h101; data_length = 16'd1;
    step(); e_rd = 2'b01; e_lba = 32'h101;
    chk("lit_cont_lba", sd_lba, 32'h0000_0101);
    sd_busy = 1'b1;
    step(); e_rd = 2'b00; e_busy = 1'b1;
    sd_busy = 1'b0; data_rd_req = 2'b00;
    sd_done = 1'b1;
    step(); e_done = 1'b1;
    sd_done = 1'b0;
    dma_sec_done = 1'b1;
    step();
    dma_sec_done = 1'b0;
    step(); e_dd = 1'b1;
    step();
    chk("lit_next_count_rd2", 32'(next_cnt), 32'd1);

    // Single-sector write, target 1: no strobe before the FIFO is filled
    data_wr_req = 2'b10; data_lba = 32'h200; data_length = 16'd1;
    step(); e_lba = 32'h200;
    step();
    sd_done = 1'b1;
    step();
    sd_done = 1'b0;
    dma_sec_done = 1'b1;
    step(); e_wr = 2'b10;
    chk("lit_wr_strobe", 32'(sd_wr), 32'h2);
    dma_sec_done = 1'b0;
    step();
    sd_busy = 1'b1;
    step(); e_wr = 2'b00; e_busy = 1'b1;
    sd_busy = 1'b0; data_wr_req = 2'b00;
    sd_done = 1'b1;
    step(); e_done = 1'b1;
    sd_done = 1'b0;
    step(); e_dd = 1'b1;
    step();

    // Zero-length read completes without touching the SD controller
    data_rd_req = 2'b01; data_lba = 32'h300; data_length = 16'd0;
    step(); e_dd = 1'b1; e_lba = 32'h300;
    data_rd_req = 2'b00;
    step();
    step();

    // Length 5 read cut short by a zero DMA sector count
    dma_scnt_zero = 1'b1;
    data_rd_req = 2'b10; data_lba = 32'h400; data_length = 16'd5;
    step(); e_rd = 2'b10; e_lba = 32'h400;
    sd_busy = 1'b1;
    step(); e_rd = 2'b00; e_busy = 1'b1;
    sd_busy = 1'b0; data_rd_req = 2'b00;
    sd_done = 1'b1;
    step(); e_done = 1'b1;
    sd_done = 1'b0;
    dma_sec_done = 1'b1;
    step();
    dma_sec_done = 1'b0;
    step(); e_dd = 1'b1;
    dma_scnt_zero = 1'b0;
    step();
    chk("lit_next_count_scnt", 32'(next_cnt), 32'd1);

    // Reset while strobing the SD controller, then a clean new write
    data_rd_req = 2'b01; data_lba = 32'h500; data_length = 16'd3;
    step(); e_rd = 2'b01; e_lba = 32'h500;
    reset = 1'b1; data_rd_req = 2'b00;
    step(); e_rd = 2'b00; e_lba = 32'h0;
    reset = 1'b0;
    step();
    step();
    data_wr_req = 2'b01; data_lba = 32'h600; data_length = 16'd1;
    step(); e_lba = 32'h600;
    dma_sec_done = 1'b1;
    step(); e_wr = 2'b01;
    dma_sec_done = 1'b0;
    sd_busy = 1'b1;
    step(); e_wr = 2'b00; e_busy = 1'b1;
    sd_busy = 1'b0; data_wr_req = 2'b00;
    sd_done = 1'b1;
    step(); e_done = 1'b1;
    sd_done = 1'b0;
    step(); e_dd = 1'b1;
    step();

    // Priority: read beats write, bit 0 beats bit 1
    data_rd_req = 2'b11; data_wr_req = 2'b11; data_lba = 32'h700; data_length = 16'd1;
    step(); e_rd = 2'b01; e_lba = 32'h700;
    reset = 1'b1; data_rd_req = 2'b00; data_wr_req = 2'b00;
    step(); e_rd = 2'b00; e_lba = 32'h0;
    reset = 1'b0;
    data_rd_req = 2'b10; data_wr_req = 2'b01; data_lba = 32'h710;
    step(); e_rd = 2'b10; e_lba = 32'h710;
    reset = 1'b1; data_rd_req = 2'b00; data_wr_req = 2'b00;
    step(); e_rd = 2'b00; e_lba = 32'h0;
    reset = 1'b0;
    step();

`ifdef ACSI_SEQ_TIMEOUT_EN
    // Missing sd_done: abort after 100 cycles in SD_WAIT
    data_rd_req = 2'b01; data_lba = 32'h800; data_length = 16'd1;
    step(); e_rd = 2'b01; e_lba = 32'h800;
    sd_busy = 1'b1;
    step(); e_rd = 2'b00; e_busy = 1'b1;
    sd_busy = 1'b0; data_rd_req = 2'b00;
    repeat (99) step();
    step(); e_dd = 1'b1; e_err = 1'b1;
    step();
    data_rd_req = 2'b01; data_lba = 32'h900; data_length = 16'd0;
    step(); e_dd = 1'b1; e_err = 1'b0; e_lba = 32'h900;
    data_rd_req = 2'b00;
    step();
`endif

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acsi_sector_seq.md
Name: acsi_sector_seq

Overview:
- Sector transfer sequencer between the ACSI command block and the SD card controller / ST DMA FIFO.
- Accepts per-target read/write sector requests, forwards them to the SD controller and sequences each 512-byte sector against the DMA engine.
- Drives the data_busy/data_done/data_next/dma_done feedback the ACSI block consumes.
- One sector in flight at a time; the ACSI block supplies the LBA of every continuation sector.

Parameters:
- TIMEOUT_CYCLES, 24'd8000000, watchdog limit per sector phase (only used with ACSI_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- data_rd_req  in  2  per-target sector read request from ACSI; held until data_busy
- data_wr_req  in  2  per-target sector write request from ACSI; held until data_busy
- data_lba  in  32  LBA of requested sector
- data_length  in  16  sectors remaining including this one
- data_busy  out  1  pulse: SD controller accepted request
- data_done  out  1  pulse: SD sector transfer finished
- data_next  out  1  pulse: request next sector
- dma_done  out  1  pulse: whole command finished
- xfer_err  out  1  level: last command aborted; cleared by next new command
- sd_rd  out  2  per-target SD read strobe
- sd_wr  out  2  per-target SD write strobe
- sd_lba  out  32  LBA to SD controller
- sd_busy  in  1  SD controller accepted strobe
- sd_done  in  1  pulse: SD sector complete
- dma_sec_done  in  1  pulse: DMA moved one 512-byte sector between FIFO and RAM
- dma_scnt_zero  in  1  level: DMA sector count register is zero

Behaviour:
- Reset values: all outputs 0, sd_lba 0, state IDLE, remaining 0.
- State IDLE:
  - Any bit of rd|wr req starts a new command: xfer_err <= 0, latch target, dir, sd_lba <= data_lba, remaining <= data_length.
  - Target priority: rd beats wr; bit 0 beats bit 1.
  - data_length == 0: no SD strobe; dma_done pulses next cycle; back to IDLE.
  - Otherwise: write -> DMA_FILL; read -> SD_REQ.
- DMA_FILL (write only): wait dma_sec_done, then SD_REQ.
- SD_REQ: sd_rd[target] (read) or sd_wr[target] (write) held high until sd_busy. On sd_busy: strobes drop the same edge, data_busy pulses 1 cycle, -> SD_WAIT.
- SD_WAIT: on sd_done, data_done pulses. Read -> DMA_DRAIN; write -> ADVANCE.
- DMA_DRAIN (read only): wait dma_sec_done, then ADVANCE.
- ADVANCE (1 cycle): remaining <= remaining - 1.
  - If remaining was 1 or dma_scnt_zero = 1: dma_done pulses, -> IDLE.
  - Else: data_next pulses, -> WAIT_NEXT.
- WAIT_NEXT: on req bit matching latched target and dir: sd_lba <= data_lba, then DMA_FILL or SD_REQ. Non-matching req bits are ignored.
- Only one of data_busy, data_done, data_next, dma_done pulses in any cycle.
- Req bits seen in states other than IDLE/WAIT_NEXT are ignored (no queueing).
- sd_done outside SD_WAIT and dma_sec_done outside DMA_FILL/DMA_DRAIN are ignored.
- remaining is 16-bit; no wrap because 0 is handled in IDLE.
- Reset mid-operation: strobes drop immediately, no pulse is emitted, state returns to IDLE.

Optional Feature:
- Macro: ACSI_SEQ_TIMEOUT_EN.
- Defined: a 24-bit watchdog clears on every state change and counts in DMA_FILL, SD_REQ, SD_WAIT, DMA_DRAIN and WAIT_NEXT. On reaching TIMEOUT_CYCLES: drop strobes, xfer_err <= 1, pulse dma_done, -> IDLE.
- Undefined: no counter; states wait forever; xfer_err is tied to 0.

Decomposition:
- Package acsi_pkg: state enum typedef (IDLE, DMA_FILL, SD_REQ, SD_WAIT, DMA_DRAIN, ADVANCE, WAIT_NEXT), SECTOR_BYTES=512, DIR_RD/DIR_WR constants.
- Sub-module: acsi_seq_watchdog (counter plus expiry compare), instantiated only under the macro.

Test Plan:
- Read, target 0, lba 0x100, length 2, dma_scnt_zero=0 -> sd_rd=01 with sd_lba 0x100; data_busy, data_done, (dma_sec_done) data_next; continuation req with lba 0x101 -> second sector; then dma_done; data_next count = 1.
- Write, target 1, length 1 -> no sd_wr until dma_sec_done; then sd_wr=10; after sd_done, dma_done.
- data_length=0 read -> no sd_rd; dma_done one cycle after req.
- Read length 5 with dma_scnt_zero=1 after first sector -> dma_done after sector 1; no data_next.
- Reset asserted in SD_REQ -> sd_rd=00 next edge; no dma_done; a new req starts cleanly.
- With ACSI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, sd_done never arrives -> dma_done and xfer_err=1 at cycle 100 of SD_WAIT.
